// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, fetch-state and branch-counter definitions
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] CTR_INIT = 2'b01;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/bht.sv
// rtl/bht.sv - branch history table of 2-bit saturating counters
module bht import mips_pkg::*; #(
  parameter int ENTRIES = 16,
  localparam int IDX = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDX-1:0] rd_idx,
  output logic [1:0]     rd_ctr,
  input  logic           upd_valid,
  input  logic [IDX-1:0] upd_idx,
  input  logic           upd_taken
);

  logic [1:0] ctr [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
    end
  end

  // Read sees the pre-update value when the same index is written this cycle.
  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage with variable-latency imem handshake and BHT prediction
module fetch_unit import mips_pkg::*; #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BHT_ENTRIES = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            StallF,
  input  logic            RedirectD,
  input  logic [XLEN-1:0] RedirectPCD,
  input  logic            BrValidD,
  input  logic [XLEN-1:0] BrPCD,
  input  logic            BrTakenD,
  output logic            IReq,
  output logic [XLEN-1:0] IAddr,
  input  logic            IAck,
  input  logic [31:0]     IRdata,
  output logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            PredTakenF,
  output logic            ValidF
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]      state;
  logic [XLEN-1:0] pc, pend_pc;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_pred;

  logic [1:0]      pred_ctr;
  logic [5:0]      op;
  logic [XLEN-1:0] pc4, jmp_tgt, br_off, br_tgt, next_pc;
  logic            pred_taken, accept;
  logic            unused_br_bits;

  bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk       (CLK),
    .rst_n     (Reset),
    .rd_idx    (pc[IDX+1:2]),
    .rd_ctr    (pred_ctr),
    .upd_valid (BrValidD),
    .upd_idx   (BrPCD[IDX+1:2]),
    .upd_taken (BrTakenD)
  );

  assign unused_br_bits = ^{BrPCD[XLEN-1:IDX+2], BrPCD[1:0]};

  // Predecode of the returning word decides where the next request goes.
  assign op      = IRdata[31:26];
  assign pc4     = pc + XLEN'(4);
  assign jmp_tgt = {pc4[XLEN-1:28], IRdata[25:0], 2'b00};
  assign br_off  = {{(XLEN-18){IRdata[15]}}, IRdata[15:0], 2'b00};
  assign br_tgt  = pc4 + br_off;

  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc4;
    case (op)
      OP_J, OP_JAL: begin
        pred_taken = 1'b1;
        next_pc    = jmp_tgt;
      end
      OP_BEQ, OP_BNE: begin
        if (pred_ctr[1]) begin
          pred_taken = 1'b1;
          next_pc    = br_tgt;
        end
      end
      default: ;
    endcase
  end

  assign accept   = ~ValidF | ~StallF;
  assign IReq     = (state == ST_REQ) || (state == ST_DRAIN);
  assign IAddr    = pc;
  assign PCPlus4F = PCF + XLEN'(4);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_pred  <= 1'b0;
      InstrF     <= '0;
      PCF        <= '0;
      PredTakenF <= 1'b0;
      ValidF     <= 1'b0;
    end else begin
      // Decode consumes or a redirect kills the current word; loads below override.
      if (RedirectD || !StallF) ValidF <= 1'b0;

      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          if (RedirectD) pc <= RedirectPCD;
        end
        ST_REQ: begin
          if (RedirectD) begin
            if (IAck) begin
              pc <= RedirectPCD;
            end else begin
              pend_pc <= RedirectPCD;
              state   <= ST_DRAIN;
            end
          end else if (IAck) begin
            pc <= next_pc;
            if (accept) begin
              InstrF     <= IRdata;
              PCF        <= pc;
              PredTakenF <= pred_taken;
              ValidF     <= 1'b1;
            end else begin
              hold_instr <= IRdata;
              hold_pc    <= pc;
              hold_pred  <= pred_taken;
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (RedirectD) begin
            pc    <= RedirectPCD;
            state <= ST_REQ;
          end else if (!StallF) begin
            InstrF     <= hold_instr;
            PCF        <= hold_pc;
            PredTakenF <= hold_pred;
            ValidF     <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          // The in-flight response is dropped; the latest redirect target wins.
          if (IAck) begin
            pc    <= RedirectD ? RedirectPCD : pend_pc;
            state <= ST_REQ;
          end else if (RedirectD) begin
            pend_pc <= RedirectPCD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
